vga_rx_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator: samples the HS/VS/RGB stream the generator drives and locks onto its timing.
- Recovers per-pixel x/y coordinates and validates line and frame lengths.
- Produces a per-frame RGB checksum, so the display pipeline can be checked in loopback on the board and in simulation.
- Sits beside the generator, clocked by the 50 MHz system clock. Pixels are qualified by a pixel-enable strobe (one pulse every 2 clocks).

---
 rtl/vga_rx_decoder_if.sv | 27 ++
 rtl/vga_rx_decoder.sv | 142 ++++++++++++++
 tb/tb_vga_rx_decoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rx_decoder_if.sv
// Sampled VGA stream into the receive decoder plus the recovered pixel and status outputs.
interface vga_rx_decoder_if;
    logic        pix_en;
    logic        hs;
    logic        vs;
    logic [7:0]  r_in;
    logic [7:0]  g_in;
    logic [7:0]  b_in;
    logic        px_valid;
    logic [11:0] px_x;
    logic [11:0] px_y;
    logic [23:0] px_rgb;
    logic        locked;
    logic        frame_done;
    logic [23:0] frame_sum;
    logic [7:0]  err_cnt;

    modport master (
        output pix_en, hs, vs, r_in, g_in, b_in,
        input  px_valid, px_x, px_y, px_rgb, locked, frame_done, frame_sum, err_cnt
    );

    modport slave (
        input  pix_en, hs, vs, r_in, g_in, b_in,
        output px_valid, px_x, px_y, px_rgb, locked, frame_done, frame_sum, err_cnt
    );
endinterface

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: locks to HS/VS timing, recovers pixel x/y, sums RGB per locked frame.
// Outputs land 1 clock after the sampling pix_en edge; no backpressure, the input stream is free-running.
module vga_rx_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 145,
    parameter int H_ACT_END   = 784,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 516,
    parameter int H_ORIGIN    = 144,
    parameter int V_ORIGIN    = 35,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    vga_rx_decoder_if.slave vif
);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_LIMIT  = 12'(H_TOTAL);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_LO = 12'(H_ACT_START);
    localparam logic [11:0] H_ACT_HI = 12'(H_ACT_END);
    localparam logic [11:0] V_ACT_LO = 12'(V_ACT_START);
    localparam logic [11:0] V_ACT_HI = 12'(V_ACT_END);
    localparam logic [11:0] H_ORG    = 12'(H_ORIGIN);
    localparam logic [11:0] V_ORG    = 12'(V_ORIGIN);
    localparam int          GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t        state;
    logic          prev_hs;
    logic          prev_vs;
    logic [11:0]   hcnt;
    logic [11:0]   vcnt;
    logic [GW-1:0] good;
    logic [23:0]   acc;

    logic        hs_fall;
    logic        vs_fall;
    logic        line_err;
    logic        frame_err;
    logic        timing_err;
    logic        active;
    logic        take_px;
    logic [23:0] px_sum;

    assign hs_fall    = prev_hs & ~vif.hs;
    assign vs_fall    = prev_vs & ~vif.vs;
    // A line either ends exactly on the last tick or has run past it without a sync edge.
    assign line_err   = hs_fall ? (hcnt != H_LAST) : (hcnt >= H_LIMIT);
    assign frame_err  = vs_fall && (vcnt != V_LAST);
    assign timing_err = (state != SEARCH) && (line_err || frame_err);
    assign active     = (hcnt >= H_ACT_LO) && (hcnt < H_ACT_HI) &&
                        (vcnt >= V_ACT_LO) && (vcnt < V_ACT_HI);
    assign take_px    = (state == LOCKED) && active;
    assign px_sum     = {16'd0, vif.r_in} + {16'd0, vif.g_in} + {16'd0, vif.b_in};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= SEARCH;
            prev_hs        <= 1'b1;
            prev_vs        <= 1'b1;
            hcnt           <= 12'd0;
            vcnt           <= 12'd0;
            good           <= '0;
            acc            <= 24'd0;
            vif.px_valid   <= 1'b0;
            vif.px_x       <= 12'd0;
            vif.px_y       <= 12'd0;
            vif.px_rgb     <= 24'd0;
            vif.locked     <= 1'b0;
            vif.frame_done <= 1'b0;
            vif.frame_sum  <= 24'd0;
            vif.err_cnt    <= 8'd0;
        end else begin
            vif.px_valid   <= 1'b0;
            vif.frame_done <= 1'b0;
            if (vif.pix_en) begin
                prev_hs <= vif.hs;
                prev_vs <= vif.vs;
                if (hs_fall) begin
                    hcnt <= 12'd0;
                    vcnt <= vcnt + 12'd1;
                end else begin
                    hcnt <= hcnt + 12'd1;
                end
                if (vs_fall) begin
                    vcnt <= 12'd0;
                end

                if (take_px) begin
                    vif.px_valid <= 1'b1;
                    vif.px_x     <= hcnt - H_ORG;
                    vif.px_y     <= vcnt - V_ORG;
                    vif.px_rgb   <= {vif.r_in, vif.g_in, vif.b_in};
                    acc          <= acc + px_sum;
                end

                // An error outranks a clean-looking vs_fall on the same tick.
                if (timing_err) begin
                    state      <= SEARCH;
                    vif.locked <= 1'b0;
                    acc        <= 24'd0;
                    good       <= '0;
                    if (vif.err_cnt != 8'hFF) begin
                        vif.err_cnt <= vif.err_cnt + 8'd1;
                    end
                end else begin
                    case (state)
                        SEARCH: begin
                            if (vs_fall) begin
                                state <= MEASURE;
                                good  <= '0;
                            end
                        end
                        MEASURE: begin
                            if (vs_fall) begin
                                if (good == GOOD_LAST) begin
                                    state      <= LOCKED;
                                    vif.locked <= 1'b1;
                                    acc        <= 24'd0;
                                end else begin
                                    good <= good + 1'b1;
                                end
                            end
                        end
                        LOCKED: begin
                            if (vs_fall) begin
                                vif.frame_done <= 1'b1;
                                vif.frame_sum  <= acc;
                                acc            <= 24'd0;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a scaled 16x10 raster: frame scenarios from a table, plus reset and saturation sequences.
module tb_vga_rx_decoder;
    localparam int HT  = 16;
    localparam int VT  = 10;
    localparam int HAS = 5;
    localparam int HAE = 13;
    localparam int VAS = 2;
    localparam int VAE = 8;
    localparam int HO  = 4;
    localparam int VO  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_rx_decoder_if vif ();

    vga_rx_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT),
        .H_ACT_START(HAS), .H_ACT_END(HAE),
        .V_ACT_START(VAS), .V_ACT_END(VAE),
        .H_ORIGIN(HO), .V_ORIGIN(VO),
        .LOCK_FRAMES(2)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .vif(vif)
    );

    int total = 0;
    int bad   = 0;

    logic        s_valid, s_done, s_locked;
    logic [11:0] s_x, s_y;
    logic [23:0] s_rgb, s_sum;
    logic [23:0] model_sum, seen_sum;
    int          vcount, dcount;

    typedef struct {
        int start_line;
        int nlines;
        int odd_line;
        int odd_len;
        int seed;
        bit exp_locked;
        int exp_err;
        int exp_done;
        int exp_sum;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix_rgb(input int seed, input int t, input int l);
        logic [7:0] r, g, b;
        if (seed == 0) begin
            r = 8'd10; g = 8'd20; b = 8'd30;
        end else begin
            r = 8'(t * 7 + seed);
            g = 8'(l * 13 + seed * 3);
            b = 8'(t * l + 200);
        end
        return {r, g, b};
    endfunction

    task automatic tick(input logic h, input logic v, input logic [23:0] rgb);
        @(negedge clk);
        vif.pix_en = 1'b1;
        vif.hs     = h;
        vif.vs     = v;
        {vif.r_in, vif.g_in, vif.b_in} = rgb;
        @(posedge clk);
        #1;
        s_valid  = vif.px_valid;
        s_done   = vif.frame_done;
        s_locked = vif.locked;
        s_x      = vif.px_x;
        s_y      = vif.px_y;
        s_rgb    = vif.px_rgb;
        s_sum    = vif.frame_sum;
        @(negedge clk);
        vif.pix_en = 1'b0;
        @(posedge clk);
        #1;
        check("pulses_idle", {vif.px_valid, vif.frame_done}, 0);
    endtask

    // Raster where the decoder's hcnt equals t: hs falls on the last tick of every line.
    task automatic send_line(input int l, input int len, input int nlines, input int seed, input bit chk_px);
        for (int t = 0; t < len; t++) begin
            logic        h, v;
            logic [23:0] rgb;
            bit          ev;
            h   = !(t == len - 1 || t < 2);
            v   = !((l == nlines - 1 && t == len - 1) || (l == 0 && t != len - 1));
            rgb = pix_rgb(seed, t, l);
            tick(h, v, rgb);
            ev = (t >= HAS) && (t < HAE) && (l >= VAS) && (l < VAE);
            if (s_valid) vcount++;
            if (s_done) begin
                dcount++;
                seen_sum = s_sum;
            end
            if (chk_px) begin
                check("px_valid", s_valid, ev);
                if (ev) begin
                    check("px_x", s_x, t - HO);
                    check("px_y", s_y, l - VO);
                    check("px_rgb", s_rgb, rgb);
                    model_sum = model_sum + 24'(rgb[23:16]) + 24'(rgb[15:8]) + 24'(rgb[7:0]);
                end
            end
        end
    endtask

    task automatic send_frame(input vec_t vv, input bit chk_px);
        model_sum = 24'd0;
        vcount    = 0;
        dcount    = 0;
        for (int l = vv.start_line; l < vv.nlines; l++) begin
            send_line(l, (l == vv.odd_line) ? vv.odd_len : HT, vv.nlines, vv.seed, chk_px);
            if (l == vv.odd_line) check("odd_line_unlock", s_locked, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          start nlines odd_line odd_len seed  lock err done sum
        vecs[0]  = '{4, VT,     -1, HT,     1, 1'b0, 0, 0, -1};
        vecs[1]  = '{0, VT,     -1, HT,     2, 1'b0, 0, 0, -1};
        vecs[2]  = '{0, VT,     -1, HT,     3, 1'b1, 0, 0, -1};
        vecs[3]  = '{0, VT,     -1, HT,     0, 1'b1, 0, 1, 2880};
        vecs[4]  = '{0, VT,     -1, HT,     9, 1'b1, 0, 1, -1};
        vecs[5]  = '{0, VT,      3, HT - 1, 4, 1'b0, 1, 0, -1};
        vecs[6]  = '{0, VT,     -1, HT,     5, 1'b0, 1, 0, -1};
        vecs[7]  = '{0, VT,     -1, HT,     6, 1'b1, 1, 0, -1};
        vecs[8]  = '{0, VT,     -1, HT,    17, 1'b1, 1, 1, -1};
        vecs[9]  = '{0, VT,      4, HT + 4, 7, 1'b0, 2, 0, -1};
        vecs[10] = '{0, VT - 1, -1, HT,     8, 1'b0, 3, 0, -1};
        vecs[11] = '{0, VT,     -1, HT,    11, 1'b0, 3, 0, -1};
        vecs[12] = '{0, VT,     -1, HT,    12, 1'b0, 3, 0, -1};
        vecs[13] = '{0, VT,     -1, HT,    13, 1'b1, 3, 0, -1};
        vecs[14] = '{0, VT,     -1, HT,    33, 1'b1, 3, 1, -1};

        reset      = 1'b1;
        vif.pix_en = 1'b0;
        vif.hs     = 1'b1;
        vif.vs     = 1'b1;
        vif.r_in   = 8'd0;
        vif.g_in   = 8'd0;
        vif.b_in   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_px_valid", vif.px_valid, 0);
        check("rst_locked", vif.locked, 0);
        check("rst_frame_done", vif.frame_done, 0);
        check("rst_err_cnt", vif.err_cnt, 0);
        check("rst_frame_sum", vif.frame_sum, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            send_frame(vecs[i], vecs[i].exp_done != 0);
            check("locked", vif.locked, vecs[i].exp_locked);
            check("err_cnt", vif.err_cnt, vecs[i].exp_err);
            check("frame_done_count", dcount, vecs[i].exp_done);
            if (vecs[i].exp_done != 0) begin
                check("px_valid_count", vcount, 48);
                check("frame_sum", seen_sum, (vecs[i].exp_sum >= 0) ? vecs[i].exp_sum : model_sum);
                check("hold_px_x", vif.px_x, 8);
                check("hold_px_y", vif.px_y, 5);
            end
        end

        // Reset in the middle of a locked frame.
        for (int l = 0; l < 4; l++) send_line(l, HT, VT, 3, 1'b0);
        check("pre_reset_locked", vif.locked, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_px_valid", vif.px_valid, 0);
        check("mid_rst_px_x", vif.px_x, 0);
        check("mid_rst_px_y", vif.px_y, 0);
        check("mid_rst_px_rgb", vif.px_rgb, 0);
        check("mid_rst_locked", vif.locked, 0);
        check("mid_rst_frame_done", vif.frame_done, 0);
        check("mid_rst_frame_sum", vif.frame_sum, 0);
        check("mid_rst_err_cnt", vif.err_cnt, 0);
        @(negedge clk);
        reset  = 1'b0;
        dcount = 0;
        for (int l = 4; l < VT; l++) send_line(l, HT, VT, 3, 1'b0);
        check("aborted_frame_done", dcount, 0);
        check("aborted_locked", vif.locked, 0);

        // hs held high in MEASURE: one timeout, then SEARCH stops further counting.
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b1, 24'd0);
        check("timeout_once", vif.err_cnt, 1);

        // Each vs pulse re-enters MEASURE and the stale hcnt times out on the next tick.
        for (int k = 0; k < 253; k++) begin
            tick(1'b1, 1'b0, 24'd0);
            tick(1'b1, 1'b1, 24'd0);
        end
        check("err_cnt_254", vif.err_cnt, 254);
        tick(1'b1, 1'b0, 24'd0);
        tick(1'b1, 1'b1, 24'd0);
        check("err_cnt_255", vif.err_cnt, 255);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 24'd0);
            tick(1'b1, 1'b1, 24'd0);
        end
        check("err_cnt_saturated", vif.err_cnt, 255);
        check("sat_locked", vif.locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
